// File: rtl/bus_rr_xbar.sv
// Round-robin multi-host to multi-device crossbar with decode-error responder and in-order tag FIFO.
// Grant is same-cycle, responses have zero added latency; a request stalls (gnt=0) while full or switching device.

module bus_rr_xbar_fifo #(
    parameter int Width = 8,
    parameter int Depth = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_vld,
    input  logic [Width-1:0]             push_dat,
    input  logic                         pop_vld,
    output logic [Width-1:0]             head_dat,
    output logic [$clog2(Depth+1)-1:0]   count
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= next_ptr(wr_ptr);
            if (pop_vld)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CntW'(push_vld) - CntW'(pop_vld);
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module bus_rr_xbar #(
    parameter int NrHosts        = 2,
    parameter int NrDevices      = 8,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NrHosts-1:0]                host_req_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
    input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [DataWidth-1:0]              host_rdata_o,
    output logic [NrHosts-1:0]                host_err_o,
    output logic [NrDevices-1:0]              device_req_o,
    output logic [AddressWidth-1:0]           device_addr_o,
    output logic                              device_we_o,
    output logic [DataWidth/8-1:0]            device_be_o,
    output logic [DataWidth-1:0]              device_wdata_o,
    input  logic [NrDevices-1:0]              device_rvalid_i,
    input  logic [NrDevices*DataWidth-1:0]    device_rdata_i,
    input  logic [NrDevices-1:0]              device_err_i,
    input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_base_i,
    input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_mask_i
);
    localparam int HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int DevW  = $clog2(NrDevices + 1);
    localparam int CntW  = $clog2(MaxOutstanding + 1);
    localparam int BeW   = DataWidth / 8;
    localparam logic [DevW-1:0] ErrDev = DevW'(NrDevices);

    typedef struct packed {
        logic [HostW-1:0] host;
        logic [DevW-1:0]  dev;
    } tag_t;

    logic [HostW-1:0]        rr_q;
    logic [HostW-1:0]        win;
    logic                    win_vld;
    logic [AddressWidth-1:0] win_addr;
    logic [DevW-1:0]         target;
    logic [DevW-1:0]         last_dev_q;
    logic                    err_pend_q;
    logic                    accept;
    logic [CntW-1:0]         count_q;
    tag_t                    head;
    tag_t                    push_tag;
    logic                    resp_fire;
    logic [NrDevices:0]      rvalid_ext;
    logic [NrDevices:0]      err_ext;
    logic [DataWidth-1:0]    rsp_rdata;
    logic [NrDevices-1:0]    expect_mask;

    always_comb begin : arb_find
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win     = '0;
        for (int i = 0; i < NrHosts; i++) begin
            idx = (int'(rr_q) + i) % NrHosts;
            if (!win_vld && host_req_i[idx]) begin
                win_vld = 1'b1;
                win     = HostW'(idx);
            end
        end
    end

    assign win_addr = host_addr_i[win*AddressWidth +: AddressWidth];

    // Scan downward so the lowest matching device index wins on overlap.
    always_comb begin
        target = ErrDev;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((win_addr & cfg_device_addr_mask_i[d*AddressWidth +: AddressWidth])
                    == cfg_device_addr_base_i[d*AddressWidth +: AddressWidth])
                target = DevW'(d);
        end
    end

    // Only one device path may be in flight at a time, so responses from devices
    // with different latencies can never overtake each other.
    assign accept = win_vld && !rst_i && (count_q < CntW'(MaxOutstanding))
                    && ((count_q == '0) || (target == last_dev_q));

    always_comb begin
        host_gnt_o     = '0;
        device_req_o   = '0;
        device_addr_o  = '0;
        device_we_o    = 1'b0;
        device_be_o    = '0;
        device_wdata_o = '0;
        if (accept) begin
            host_gnt_o     = NrHosts'(1) << win;
            if (target != ErrDev) device_req_o = NrDevices'(1) << target;
            device_addr_o  = win_addr;
            device_we_o    = host_we_i[win];
            device_be_o    = host_be_i[win*BeW +: BeW];
            device_wdata_o = host_wdata_i[win*DataWidth +: DataWidth];
        end
    end

    assign push_tag = {win, target};

    bus_rr_xbar_fifo #(
        .Width ($bits(tag_t)),
        .Depth (MaxOutstanding)
    ) u_tag_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push_vld (accept),
        .push_dat (push_tag),
        .pop_vld  (resp_fire),
        .head_dat (head),
        .count    (count_q)
    );

    // The pseudo-device ERR sits at index NrDevices of these extended vectors.
    assign rvalid_ext = {err_pend_q, device_rvalid_i};
    assign err_ext    = {1'b1, device_err_i};

    always_comb begin
        rsp_rdata = '0;
        for (int d = 0; d < NrDevices; d++) begin
            if (head.dev == DevW'(d)) rsp_rdata = device_rdata_i[d*DataWidth +: DataWidth];
        end
    end

    assign resp_fire     = !rst_i && (count_q != '0) && rvalid_ext[head.dev];
    assign host_rvalid_o = resp_fire ? (NrHosts'(1) << head.host) : '0;
    assign host_err_o    = (resp_fire && err_ext[head.dev]) ? (NrHosts'(1) << head.host) : '0;
    assign host_rdata_o  = resp_fire ? rsp_rdata : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            last_dev_q <= '0;
            err_pend_q <= 1'b0;
        end else begin
            err_pend_q <= accept && (target == ErrDev);
            if (accept) begin
                rr_q       <= (win == HostW'(NrHosts - 1)) ? '0 : win + 1'b1;
                last_dev_q <= target;
            end
        end
    end

    assign expect_mask = ((count_q != '0) && (head.dev != ErrDev)) ? (NrDevices'(1) << head.dev) : '0;

    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert ((device_rvalid_i & ~expect_mask) == '0)
                else $warning("bus_rr_xbar: unexpected device_rvalid_i %b dropped", device_rvalid_i);
        end
    end
endmodule

// File: tb/tb_bus_rr_xbar.sv
// Randomised and directed bench for bus_rr_xbar against a queue-based reference model.
// Device models answer after a fixed per-device latency; every output is compared each cycle.
module tb_bus_rr_xbar;
    localparam int NH = 3;
    localparam int ND = 8;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 2;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NH-1:0]    host_req = '0, host_gnt, host_we = '0, host_rvalid, host_err;
    logic [NH*AW-1:0] host_addr = '0;
    logic [NH*BW-1:0] host_be = '0;
    logic [NH*DW-1:0] host_wdata = '0;
    logic [DW-1:0]    host_rdata;
    logic [ND-1:0]    device_req, device_rvalid = '0, device_err = '0;
    logic [AW-1:0]    device_addr;
    logic             device_we;
    logic [BW-1:0]    device_be;
    logic [DW-1:0]    device_wdata;
    logic [ND*DW-1:0] device_rdata = '0;
    logic [ND*AW-1:0] cfg_base, cfg_mask;

    bus_rr_xbar #(
        .NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
        .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
        .device_req_o(device_req), .device_addr_o(device_addr), .device_we_o(device_we),
        .device_be_o(device_be), .device_wdata_o(device_wdata),
        .device_rvalid_i(device_rvalid), .device_rdata_i(device_rdata), .device_err_i(device_err),
        .cfg_device_addr_base_i(cfg_base), .cfg_device_addr_mask_i(cfg_mask)
    );

    typedef struct { int due; int dev; logic [31:0] data; logic err; } dresp_t;
    typedef struct { int host; int dev; int due; } ent_t;
    typedef struct { int host; int cyc; } glog_t;

    int          lat [ND] = '{1, 3, 2, 1, 2, 1, 1, 2};
    logic [31:0] base[ND];
    logic [31:0] mask[ND];
    dresp_t      dq[$];
    ent_t        mq[$];
    glog_t       glog[$];
    int          rlog_host[$];
    int          rlog_cyc[$];
    logic [31:0] rlog_dat[$];
    logic        rlog_err[$];
    logic [ND-1:0] last_dreq;
    bit   [NH-1:0] h_req = '0;
    bit   [NH-1:0] h_we = '0;
    logic [31:0] h_addr [NH];
    logic [3:0]  h_be   [NH];
    logic [31:0] h_wdata[NH];
    int          iss[NH];
    int          rr_m, last_m, cyc, c0;
    int          n_tests = 0, n_fail = 0;

    function automatic logic [31:0] dev_data(input logic [31:0] a, input int d);
        return a ^ 32'h5A5A_0000 ^ 32'(d);
    endfunction

    function automatic int decode(input logic [31:0] a);
        for (int d = 0; d < ND; d++) if ((a & mask[d]) == base[d]) return d;
        return ND;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        logic [ND-1:0]    rv, re, e_req;
        logic [ND*DW-1:0] rd;
        logic [NH-1:0]    e_gnt, e_rv, e_er;
        logic [31:0]      e_addr, e_wd, e_rd;
        logic [3:0]       e_be;
        logic             e_we, rsp_err;
        int               win, tgt, idx;
        bit               acc, fire;
        @(negedge clk);
        rv = '0; re = '0; rd = '0;
        for (int i = 0; i < dq.size(); i++) begin
            if (dq[i].due == cyc) begin
                rv[dq[i].dev] = 1'b1;
                re[dq[i].dev] = dq[i].err;
                rd[dq[i].dev*DW +: DW] = dq[i].data;
            end
        end
        for (int i = dq.size() - 1; i >= 0; i--) if (dq[i].due <= cyc) dq.delete(i);
        device_rvalid = rv; device_err = re; device_rdata = rd;
        for (int h = 0; h < NH; h++) begin
            host_req[h] = h_req[h];
            host_we[h]  = h_we[h];
            host_addr[h*AW +: AW]  = h_addr[h];
            host_be[h*BW +: BW]    = h_be[h];
            host_wdata[h*DW +: DW] = h_wdata[h];
        end
        #1;
        e_gnt = '0; e_req = '0; e_rv = '0; e_er = '0;
        e_addr = '0; e_wd = '0; e_rd = '0; e_be = '0; e_we = 1'b0;
        win = -1; tgt = ND; acc = 1'b0; fire = 1'b0; rsp_err = 1'b0;
        if (!rst) begin
            for (int i = 0; i < NH; i++) begin
                idx = (rr_m + i) % NH;
                if (win < 0 && h_req[idx]) win = idx;
            end
            if (win >= 0) begin
                tgt = decode(h_addr[win]);
                acc = (mq.size() < MO) && (mq.size() == 0 || tgt == last_m);
            end
            if (acc) begin
                e_gnt[win] = 1'b1;
                if (tgt < ND) e_req[tgt] = 1'b1;
                e_addr = h_addr[win]; e_we = h_we[win]; e_be = h_be[win]; e_wd = h_wdata[win];
            end
            if (mq.size() > 0) begin
                if (mq[0].dev == ND) begin
                    fire = (mq[0].due == cyc);
                    rsp_err = 1'b1;
                end else begin
                    fire = rv[mq[0].dev];
                    rsp_err = re[mq[0].dev];
                    e_rd = rd[mq[0].dev*DW +: DW];
                end
                if (fire) begin
                    e_rv[mq[0].host] = 1'b1;
                    e_er[mq[0].host] = rsp_err;
                end else e_rd = '0;
            end
        end
        check("gnt", 64'(host_gnt), 64'(e_gnt));
        check("dev_req", 64'(device_req), 64'(e_req));
        check("dev_addr", 64'(device_addr), 64'(e_addr));
        check("dev_we", 64'(device_we), 64'(e_we));
        check("dev_be", 64'(device_be), 64'(e_be));
        check("dev_wdata", 64'(device_wdata), 64'(e_wd));
        check("rvalid", 64'(host_rvalid), 64'(e_rv));
        check("rerr", 64'(host_err), 64'(e_er));
        check("rdata", 64'(host_rdata), 64'(e_rd));
        for (int h = 0; h < NH; h++) begin
            if (host_gnt[h]) begin
                glog.push_back('{h, cyc});
                last_dreq = device_req;
            end
            if (host_rvalid[h]) begin
                rlog_host.push_back(h); rlog_cyc.push_back(cyc);
                rlog_dat.push_back(host_rdata); rlog_err.push_back(host_err[h]);
            end
        end
        if (fire) void'(mq.pop_front());
        if (acc) begin
            mq.push_back('{win, tgt, cyc + 1});
            last_m = tgt;
            rr_m = (win + 1) % NH;
            h_req[win] = 1'b0;
            if (tgt < ND) dq.push_back('{cyc + lat[tgt], tgt, dev_data(h_addr[win], tgt), tgt == 5});
        end
        cyc++;
    endtask

    task automatic clear_logs();
        glog.delete(); rlog_host.delete(); rlog_cyc.delete(); rlog_dat.delete(); rlog_err.delete();
        last_dreq = '0;
    endtask

    task automatic do_reset(input bit keep_dev, input int ncyc);
        host_req = '1;
        rst = 1'b1;
        #1;
        check("rst_gnt", 64'(host_gnt), 64'd0);
        check("rst_dev_req", 64'(device_req), 64'd0);
        check("rst_rvalid", 64'(host_rvalid), 64'd0);
        check("rst_dev_addr", 64'(device_addr), 64'd0);
        mq.delete(); rr_m = 0; last_m = 0; h_req = '0;
        if (!keep_dev) dq.delete();
        repeat (ncyc) step();
        rst = 1'b0;
        clear_logs();
        for (int h = 0; h < NH; h++) iss[h] = 0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((mq.size() != 0 || dq.size() != 0 || h_req != '0) && n < 200) begin
            step();
            n++;
        end
        check(tag, 64'(mq.size() + dq.size() + int'(h_req != '0)), 64'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        logic [31:0] off;
        r = $urandom_range(0, ND);
        off = $urandom & 32'h0000_0FFC;
        return (r == ND) ? (32'hDEAD_0000 | off) : (base[r] | off);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < ND; d++) begin
            base[d] = 32'h8000_0000 + 32'(d) * 32'h1000;
            mask[d] = 32'hFFFF_F000;
        end
        base[0] = 32'h0010_0000; mask[0] = 32'hFFF0_0000;
        base[1] = 32'h0020_0000;
        base[3] = 32'h8000_2000;
        for (int d = 0; d < ND; d++) begin
            cfg_base[d*AW +: AW] = base[d];
            cfg_mask[d*AW +: AW] = mask[d];
        end
        for (int h = 0; h < NH; h++) begin
            h_addr[h] = '0; h_be[h] = 4'hF; h_wdata[h] = '0; iss[h] = 0;
        end
        cyc = 0;

        // Round-robin between hosts 0 and 1 on RAM
        do_reset(1'b0, 2);
        c0 = cyc;
        for (int k = 0; k < 12 && glog.size() < 4; k++) begin
            for (int h = 0; h < 2; h++) begin
                if (!h_req[h] && iss[h] < 2) begin
                    h_req[h] = 1'b1; h_addr[h] = 32'h0010_0000; h_we[h] = 1'b0; iss[h]++;
                end
            end
            step();
        end
        drain("rr_drain");
        check("rr_grants", 64'(glog.size()), 64'd4);
        check("rr_resps", 64'(rlog_cyc.size()), 64'd4);
        for (int i = 0; i < 4 && i < glog.size() && i < rlog_cyc.size(); i++) begin
            check("rr_host", 64'(glog[i].host), 64'(i % 2));
            check("rr_gnt_cyc", 64'(glog[i].cyc), 64'(c0 + i));
            check("rr_rv_host", 64'(rlog_host[i]), 64'(i % 2));
            check("rr_rv_cyc", 64'(rlog_cyc[i]), 64'(c0 + i + 1));
            check("rr_rdata", 64'(rlog_dat[i]), 64'(dev_data(32'h0010_0000, 0)));
        end

        // Decode error
        do_reset(1'b0, 2);
        c0 = cyc;
        h_req[0] = 1'b1; h_addr[0] = 32'hDEAD_0000; h_we[0] = 1'b0;
        step(); step(); step();
        check("derr_grants", 64'(glog.size()), 64'd1);
        check("derr_resps", 64'(rlog_cyc.size()), 64'd1);
        if (glog.size() > 0 && rlog_cyc.size() > 0) begin
            check("derr_gnt_cyc", 64'(glog[0].cyc), 64'(c0));
            check("derr_dev_req", 64'(last_dreq), 64'd0);
            check("derr_rv_cyc", 64'(rlog_cyc[0]), 64'(c0 + 1));
            check("derr_err", 64'(rlog_err[0]), 64'd1);
            check("derr_rdata", 64'(rlog_dat[0]), 64'd0);
        end

        // Outstanding limit against 3-cycle device 1
        do_reset(1'b0, 2);
        c0 = cyc;
        for (int k = 0; k < 12 && glog.size() < 3; k++) begin
            if (!h_req[0] && iss[0] < 3) begin
                h_req[0] = 1'b1; h_addr[0] = 32'h0020_0000 + 32'(iss[0] * 4); iss[0]++;
            end
            step();
        end
        drain("lim_drain");
        check("lim_grants", 64'(glog.size()), 64'd3);
        check("lim_resps", 64'(rlog_cyc.size()), 64'd3);
        if (glog.size() == 3 && rlog_cyc.size() == 3) begin
            check("lim_gnt1", 64'(glog[1].cyc), 64'(c0 + 1));
            check("lim_gnt2", 64'(glog[2].cyc), 64'(c0 + 4));
            check("lim_pop0", 64'(rlog_cyc[0]), 64'(c0 + 3));
            check("lim_rdata0", 64'(rlog_dat[0]), 64'(dev_data(32'h0020_0000, 1)));
        end

        // Device switch waits for the slow path to empty
        do_reset(1'b0, 2);
        c0 = cyc;
        h_req[0] = 1'b1; h_addr[0] = 32'h0020_0040;
        step();
        h_req[1] = 1'b1; h_addr[1] = 32'h0010_0080; h_we[1] = 1'b0;
        drain("sw_drain");
        check("sw_grants", 64'(glog.size()), 64'd2);
        check("sw_resps", 64'(rlog_cyc.size()), 64'd2);
        if (glog.size() == 2 && rlog_cyc.size() == 2) begin
            check("sw_gnt_cyc", 64'(glog[1].cyc), 64'(c0 + 4));
            check("sw_order0", 64'(rlog_host[0]), 64'd0);
            check("sw_order1", 64'(rlog_host[1]), 64'd1);
            check("sw_rv_cyc", 64'(rlog_cyc[1]), 64'(c0 + 5));
        end

        // Overlapping windows: lowest index wins
        do_reset(1'b0, 2);
        h_req[0] = 1'b1; h_addr[0] = 32'h8000_2004;
        drain("ovl_drain");
        check("ovl_dev_req", 64'(last_dreq), 64'h04);

        // Reset with two requests in flight, late responses afterwards
        do_reset(1'b0, 2);
        h_req[0] = 1'b1; h_addr[0] = 32'h0020_0000; step();
        h_req[0] = 1'b1; h_addr[0] = 32'h0020_0004; step();
        check("rmid_inflight", 64'(mq.size()), 64'd2);
        #2;
        do_reset(1'b1, 1);
        step(); step();
        check("rmid_late_rv", 64'(rlog_cyc.size()), 64'd0);
        h_req[0] = 1'b1; h_addr[0] = 32'h0010_0000;
        h_req[1] = 1'b1; h_addr[1] = 32'h0010_0004;
        drain("rmid_drain");
        check("rmid_grants", 64'(glog.size()), 64'd2);
        if (glog.size() == 2) begin
            check("rmid_first", 64'(glog[0].host), 64'd0);
            check("rmid_second", 64'(glog[1].host), 64'd1);
        end

        // Randomised traffic
        do_reset(1'b0, 2);
        repeat (1500) begin
            for (int h = 0; h < NH; h++) begin
                if (!h_req[h] && $urandom_range(0, 1) == 1) begin
                    h_req[h]   = 1'b1;
                    h_addr[h]  = rand_addr();
                    h_we[h]    = 1'($urandom);
                    h_be[h]    = 4'($urandom);
                    h_wdata[h] = $urandom;
                end
            end
            step();
        end
        drain("rand_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
